// File: rtl/csr_job_ctrl.sv
// Line-copy job controller: decodes MMIO writes into a job register bank, issues
// credit-limited per-line copy requests and tracks completions to raise the done flag.
module csr_job_ctrl #(
  parameter logic [15:0] BASE_DW         = 16'h0040,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pkt_valid,
  input  logic [15:0] pkt_addr,
  input  logic [63:0] pkt_data,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [41:0] req_src,
  output logic [41:0] req_dst,
  input  logic        cpl_valid,
  output logic        sync,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = 42;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One extra bit so MAX_OUTSTANDING never aliases inside a narrow counter.
  localparam logic [CNT_W:0] MAX_OUT = (CNT_W + 1)'(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [CNT_W-1:0] nlines_q, nlines_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic             req_valid_q, req_valid_d;
  logic [AW-1:0]    req_src_q, req_src_d;
  logic [AW-1:0]    req_dst_q, req_dst_d;
  logic             sync_q, sync_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------------
  // MMIO write decode
  // ---------------------------------------------------------------------------
  logic wr_src, wr_dst, wr_nlines, wr_ctrl;
  logic ctrl_start, ctrl_abort, ctrl_clear;

  assign wr_src    = pkt_valid && (pkt_addr == BASE_DW);
  assign wr_dst    = pkt_valid && (pkt_addr == BASE_DW + 16'd2);
  assign wr_nlines = pkt_valid && (pkt_addr == BASE_DW + 16'd4);
  assign wr_ctrl   = pkt_valid && (pkt_addr == BASE_DW + 16'd6);

  assign ctrl_start = wr_ctrl && pkt_data[0];
  assign ctrl_abort = wr_ctrl && pkt_data[1];
  assign ctrl_clear = wr_ctrl && pkt_data[2];

  logic unused_pkt_data;
  assign unused_pkt_data = ^pkt_data[63:AW];

  // ---------------------------------------------------------------------------
  // Handshake, completion accounting and credit
  // ---------------------------------------------------------------------------
  logic             fire;
  logic             cpl_ok;
  logic             cpl_spurious;
  logic             none_outstanding;
  logic [CNT_W-1:0] issued_inc;
  logic [CNT_W-1:0] completed_inc;
  logic             credit_ok;

  assign busy             = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign fire             = req_valid_q && req_ready;
  assign none_outstanding = (issued_q == completed_q);

  // Completions seen in IDLE can only be leftovers from before a reset.
  assign cpl_ok       = cpl_valid && (state_q != ST_IDLE) && (!none_outstanding || fire);
  assign cpl_spurious = cpl_valid && (state_q != ST_IDLE) && none_outstanding && !fire;

  assign issued_inc    = issued_q + CNT_W'(fire);
  assign completed_inc = completed_q + CNT_W'(cpl_ok);
  assign credit_ok     = {1'b0, issued_inc - completed_inc} < MAX_OUT;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic err_set;

  // NOTE: every signal driven here gets a default first, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    nlines_d    = nlines_q;
    issued_d    = issued_inc;
    completed_d = completed_inc;
    req_valid_d = req_valid_q;
    req_src_d   = req_src_q;
    req_dst_d   = req_dst_q;
    sync_d      = sync_q;
    err_set     = cpl_spurious;

    // Job configuration is frozen while a job is running.
    if (!busy) begin
      if (wr_src)    src_d    = pkt_data[AW-1:0];
      if (wr_dst)    dst_d    = pkt_data[AW-1:0];
      if (wr_nlines) nlines_d = pkt_data[CNT_W-1:0];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) sync_d = 1'b1;
        if (ctrl_start) begin
          issued_d    = '0;
          completed_d = '0;
          sync_d      = 1'b0;
          if (nlines_q != '0) begin
            state_d     = ST_ISSUE;
            req_valid_d = 1'b1;
            req_src_d   = src_q;
            req_dst_d   = dst_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        if (ctrl_abort) begin
          state_d     = ST_DRAIN;
          req_valid_d = 1'b0;
          err_set     = 1'b1;
        end else if (issued_inc == nlines_q) begin
          state_d     = ST_DRAIN;
          req_valid_d = 1'b0;
        end else if (!(req_valid_q && !fire)) begin
          // A stalled request keeps its address; otherwise present the next line.
          req_valid_d = credit_ok;
          req_src_d   = src_q + AW'(issued_inc);
          req_dst_d   = dst_q + AW'(issued_inc);
        end
      end

      ST_DRAIN: begin
        if (none_outstanding) begin
          state_d = ST_DONE;
          sync_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new error in the same cycle as clear_err wins.
    err_d = err_q;
    if (ctrl_clear) err_d = 1'b0;
    if (err_set)    err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      nlines_q    <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      req_valid_q <= 1'b0;
      req_src_q   <= '0;
      req_dst_q   <= '0;
      sync_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      nlines_q    <= nlines_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      req_valid_q <= req_valid_d;
      req_src_q   <= req_src_d;
      req_dst_q   <= req_dst_d;
      sync_q      <= sync_d;
      err_q       <= err_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_src   = req_src_q;
  assign req_dst   = req_dst_q;
  assign sync      = sync_q;
  assign err       = err_q;

endmodule

// File: doc/csr_job_ctrl.md
Name: csr_job_ctrl

Overview:
- Consumer of the MMIO-write packet stream (valid/addr/data) that the CSR block produces.
- Decodes the writes into a job register bank and runs a line-copy job sequencer.
- Issues per-line requests, with credit limiting, to the downstream copy engine and counts completions.
- Returns the job-done flag as `sync` to the CSR block, which exposes it at MMIO byte offset 0x300.

Parameters:
- BASE_DW, 16'h0040: DW address of the first job register (byte 0x100).
- MAX_OUTSTANDING, 64: maximum number of issued requests not yet completed. Power of two, 2..256.
- CNT_W, 32: width of the line count and the line counters.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: synchronous reset, active-low.
- pkt_valid, input, 1: MMIO write packet valid, single-cycle per write.
- pkt_addr, input, 16: MMIO DW address (byte address >> 2).
- pkt_data, input, 64: MMIO write data.
- req_valid, output, 1: line request valid.
- req_ready, input, 1: downstream accepts the request.
- req_src, output, 42: source cache-line address.
- req_dst, output, 42: destination cache-line address.
- cpl_valid, input, 1: one line completed (pulse per line).
- sync, output, 1: job done flag to the CSR block.
- busy, output, 1: job in progress.
- err, output, 1: sticky error: abort, or completion with none outstanding.

Behaviour:
- **Register map** (DW address relative to BASE_DW; a match also requires pkt_valid):
  - +0 SRC: bits [41:0].
  - +2 DST: bits [41:0].
  - +4 NLINES: bits [CNT_W-1:0].
  - +6 CTRL: bit0 start, bit1 abort, bit2 clear_err. Self-clearing, never stored.
  - Other addresses ignored. Upper data bits ignored.
- **Write timing:** a write at edge t is visible in the register at t+1.
- **Config lock:** writes to SRC/DST/NLINES while busy=1 are dropped.
- **Reset** (reset_n=0 at an edge), all of:
  - all registers and counters 0; state IDLE.
  - req_valid=0, busy=0, sync=0, err=0.
  - Reset mid-job discards all progress. Completions in flight after reset are ignored and do not set err.
- **FSM** states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE or DONE + start: clear issued, completed and outstanding counts; sync<=0. Next state is ISSUE if NLINES≠0, else DONE with sync<=1 on the next edge (NLINES=0 gives a 2-cycle done).
  - ISSUE: req_valid=1 when outstanding<MAX_OUTSTANDING. req_src=SRC+issued and req_dst=DST+issued, both wrapping modulo 2^42.
    - Handshake fires on req_valid & req_ready; issued+=1.
    - When issued reaches NLINES → DRAIN.
    - req_valid/req_src/req_dst are registered outputs. Once req_valid is asserted, the address stays stable until accepted.
  - DRAIN: req_valid=0. When completed==issued → DONE, sync<=1.
  - DONE: sync held 1 until the next start.
- **Counts and errors:**
  - outstanding = issued − completed. A same-cycle handshake and cpl_valid leaves it unchanged.
  - cpl_valid with outstanding=0 (and no same-cycle handshake) is ignored and sets err.
- **Abort** (CTRL bit1):
  - In ISSUE: drop req_valid next cycle, go to DRAIN, set err. A handshake in the abort cycle itself still counts.
  - In IDLE/DONE: no effect.
- **Start edge cases:**
  - start while busy: ignored.
  - start+abort in the same write: abort wins when busy; start wins when idle.
- **Output definitions:**
  - busy = state is ISSUE or DRAIN.
  - err clears only on clear_err or reset. clear_err in the same cycle as a new error event: err stays 1.

Test Plan:
- **Basic job:** write SRC=0x1000, DST=0x2000, NLINES=4, CTRL=1; req_ready=1; each cpl_valid 3 cycles after its request → requests src 0x1000..0x1003 / dst 0x2000..0x2003; busy for the job; sync=1 after the 4th completion; err=0.
- **Zero lines:** NLINES=0, start → no req_valid; sync=1 two cycles after the CTRL write.
- **Credit limit:** MAX_OUTSTANDING=4, NLINES=10, no completions → exactly 4 handshakes, then req_valid=0. One cpl_valid → exactly one more request issued. Finish → sync=1.
- **Backpressure and address wrap:** SRC=0x3FF_FFFF_FFFF, NLINES=2, req_ready low 5 cycles → req_src held stable while stalled; second request req_src=0.
- **Abort mid-job:** NLINES=100, abort after 10 handshakes with 3 outstanding → no further requests; sync=1 after the 3 completions; err=1. clear_err → err=0. A config write to NLINES while busy is ignored (job length unchanged).
- **Reset mid-job:** reset_n low 1 cycle during ISSUE → all outputs 0. A stray cpl_valid afterwards → err stays 0. A new job then runs normally.
